// File: rtl/mem_xfer_pkg.sv
// Shared types and helpers for the load/store memory transfer sequencer.
package mem_xfer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    MAR,
    DSEL,
    MDRW,
    WWAIT,
    RWAIT,
    MDRR,
    DRIVE,
    WB,
    DONE,
    FAIL
  } state_e;

  localparam logic [3:0] OPC_LOAD_DEF  = 4'b0011;
  localparam logic [3:0] OPC_STORE_DEF = 4'b0100;

  // Widest register file the one-hot helper can describe.
  localparam int unsigned MAX_REGS = 32;

  // Scalar control strobes, registered together in the sequencer.
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic mem_en;
    logic rw;
    logic mar_in;
    logic mdr_wr;
    logic mdr_rd;
    logic mdr_out;
    logic pc_inc;
  } ctrl_t;

  // Register index k selects one-hot bit nregs-1-k (register 0 is the MSB).
  function automatic logic [MAX_REGS-1:0] reg_onehot(input int unsigned index,
                                                      input int unsigned nregs);
    logic [MAX_REGS-1:0] one;
    one = {{(MAX_REGS-1){1'b0}}, 1'b1};
    if ((index < nregs) && (nregs <= MAX_REGS)) begin
      return one << (nregs - 1 - index);
    end
    return '0;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MFC-low cycles while the sequencer waits on memory; flags the last allowed cycle.
module mem_wait_timer
  import mem_xfer_pkg::*;
#(
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  input  logic MFC,
  output logic expired
);

  localparam int unsigned CW = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MFC_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = (count_q == LAST);

  // Clear outside wait states, advance on each MFC-low wait cycle, hold once expired.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && !MFC && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_xfer_fsm.sv
// Load/store sequencer: steps register file, MAR, MDR and memory through one transfer
// per accepted start, with MFC timeout and invalid-register error reporting.
module mem_xfer_fsm
  import mem_xfer_pkg::*;
#(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned NREGS       = 6,
  parameter logic [3:0]  OPC_LOAD    = OPC_LOAD_DEF,
  parameter logic [3:0]  OPC_STORE   = OPC_STORE_DEF,
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               MFC,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               memEN,
  output logic               RW,
  output logic               marIn,
  output logic               mdrWriteEN,
  output logic               mdrReadEN,
  output logic               mdrOut,
  output logic               pcInc,
  output logic [NREGS-1:0]   rxOut,
  output logic [NREGS-1:0]   rxIn
);

  localparam int unsigned PW    = (INSTR_W - 4) / 2;
  localparam int unsigned P1_HI = INSTR_W - 5;
  localparam int unsigned P2_HI = INSTR_W - 5 - PW;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [NREGS-1:0]   rx_out_q, rx_out_d;
  logic [NREGS-1:0]   rx_in_q, rx_in_d;

  logic [3:0]    opc_in;
  logic [PW-1:0] p1_in, p2_in;
  logic          ls_in, regs_ok;
  logic [3:0]    opc_q;
  logic [NREGS-1:0] sel_p1, sel_p2;
  logic          in_wait, timer_expired;

  assign opc_in  = instruction[INSTR_W-1 -: 4];
  assign p1_in   = instruction[P1_HI -: PW];
  assign p2_in   = instruction[P2_HI -: PW];
  assign ls_in   = (opc_in == OPC_LOAD) || (opc_in == OPC_STORE);
  assign regs_ok = (32'(p1_in) < NREGS) && (32'(p2_in) < NREGS);
  assign opc_q   = instr_q[INSTR_W-1 -: 4];

  // Selects follow the next latched instruction so they register alongside the state.
  assign sel_p1 = NREGS'(reg_onehot(32'(instr_d[P1_HI -: PW]), NREGS));
  assign sel_p2 = NREGS'(reg_onehot(32'(instr_d[P2_HI -: PW]), NREGS));

  assign in_wait = (state_q == WWAIT) || (state_q == RWAIT);

  mem_wait_timer #(
    .MFC_TIMEOUT(MFC_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .count_en(in_wait),
    .MFC     (MFC),
    .expired (timer_expired)
  );

  // Next-state and instruction latch.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: begin
        if (start && ls_in) begin
          if (!regs_ok) begin
            state_d = FAIL;
          end else begin
            instr_d = instruction;
            state_d = ADDR;
          end
        end
      end
      ADDR:  state_d = MAR;
      MAR:   state_d = (opc_q == OPC_STORE) ? DSEL : RWAIT;
      DSEL:  state_d = MDRW;
      MDRW:  state_d = WWAIT;
      WWAIT: begin
        if (MFC) begin
          state_d = DONE;
        end else if (timer_expired) begin
          state_d = FAIL;
        end
      end
      RWAIT: begin
        if (MFC) begin
          state_d = MDRR;
        end else if (timer_expired) begin
          state_d = FAIL;
        end
      end
      MDRR:  state_d = DRIVE;
      DRIVE: state_d = WB;
      WB:    state_d = DONE;
      DONE:  state_d = IDLE;
      FAIL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the next state, registered so they line up with state_q.
  always_comb begin
    ctrl_d      = '0;
    rx_out_d    = '0;
    rx_in_d     = '0;
    ctrl_d.busy = (state_d != IDLE);
    unique case (state_d)
      ADDR: begin
        rx_out_d      = sel_p2;
        ctrl_d.pc_inc = 1'b1;
      end
      MAR: begin
        rx_out_d      = sel_p2;
        ctrl_d.mar_in = 1'b1;
      end
      DSEL: rx_out_d = sel_p1;
      MDRW: begin
        rx_out_d      = sel_p1;
        ctrl_d.mdr_wr = 1'b1;
      end
      WWAIT: ctrl_d.mem_en = 1'b1;
      RWAIT: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.rw     = 1'b1;
      end
      MDRR: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.rw     = 1'b1;
        ctrl_d.mdr_rd = 1'b1;
      end
      DRIVE: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.rw      = 1'b1;
      end
      WB: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.rw      = 1'b1;
        rx_in_d        = sel_p1;
      end
      DONE: ctrl_d.done = 1'b1;
      FAIL: begin
        ctrl_d.done = 1'b1;
        ctrl_d.err  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched instruction and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      ctrl_q   <= '0;
      rx_out_q <= '0;
      rx_in_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      ctrl_q   <= ctrl_d;
      rx_out_q <= rx_out_d;
      rx_in_q  <= rx_in_d;
    end
  end

  assign busy       = ctrl_q.busy;
  assign done       = ctrl_q.done;
  assign err        = ctrl_q.err;
  assign memEN      = ctrl_q.mem_en;
  assign RW         = ctrl_q.rw;
  assign marIn      = ctrl_q.mar_in;
  assign mdrWriteEN = ctrl_q.mdr_wr;
  assign mdrReadEN  = ctrl_q.mdr_rd;
  assign mdrOut     = ctrl_q.mdr_out;
  assign pcInc      = ctrl_q.pc_inc;
  assign rxOut      = rx_out_q;
  assign rxIn       = rx_in_q;

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Bench for mem_xfer_fsm: per-transfer expected traces built from the operation rules,
// compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_mem_xfer_fsm;

  localparam int NR  = 6;
  localparam int TMO = 4;
  localparam logic [3:0] OP_LD = 4'b0011;
  localparam logic [3:0] OP_ST = 4'b0100;

  // Output vector layout: {busy,done,err,memEN,RW,marIn,mdrWriteEN,mdrReadEN,mdrOut,pcInc,rxOut,rxIn}
  localparam logic [21:0] F_BUSY   = 22'h200000;
  localparam logic [21:0] F_DONE   = 22'h100000;
  localparam logic [21:0] F_ERR    = 22'h080000;
  localparam logic [21:0] F_MEMEN  = 22'h040000;
  localparam logic [21:0] F_RW     = 22'h020000;
  localparam logic [21:0] F_MARIN  = 22'h010000;
  localparam logic [21:0] F_MDRW   = 22'h008000;
  localparam logic [21:0] F_MDRR   = 22'h004000;
  localparam logic [21:0] F_MDROUT = 22'h002000;
  localparam logic [21:0] F_PCINC  = 22'h001000;

  logic        clk = 1'b0;
  logic        rst, start, MFC;
  logic [15:0] instruction;
  logic        busy, done, err, memEN, RW, marIn, mdrWriteEN, mdrReadEN, mdrOut, pcInc;
  logic [NR-1:0] rxOut, rxIn;

  logic [21:0] dut_vec;
  logic [21:0] exp_vec;
  logic [21:0] exp_tr[$];
  int          mfc_plan[$];   // 0/1 = forced MFC in that cycle, 2 = don't care (randomised)
  logic [21:0] got [0:63];
  int          n_pass = 0;
  int          n_total = 0;
  bit          chk_en = 1'b0;

  mem_xfer_fsm #(
    .INSTR_W    (16),
    .NREGS      (NR),
    .OPC_LOAD   (OP_LD),
    .OPC_STORE  (OP_ST),
    .MFC_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instruction(instruction),
    .MFC        (MFC),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .memEN      (memEN),
    .RW         (RW),
    .marIn      (marIn),
    .mdrWriteEN (mdrWriteEN),
    .mdrReadEN  (mdrReadEN),
    .mdrOut     (mdrOut),
    .pcInc      (pcInc),
    .rxOut      (rxOut),
    .rxIn       (rxIn)
  );

  always #5 clk = ~clk;

  assign dut_vec = {busy, done, err, memEN, RW, marIn, mdrWriteEN, mdrReadEN, mdrOut, pcInc,
                    rxOut, rxIn};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Single per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) chk("outputs", 32'(dut_vec), 32'(exp_vec));
  end

  // Register k drives one-hot bit NR-1-k.
  function automatic logic [5:0] sel(input int k);
    logic [5:0] msb;
    msb = 6'b100000;
    return msb >> k;
  endfunction

  function automatic logic [21:0] ro(input logic [5:0] s);
    return {10'b0, s, 6'b0};
  endfunction

  function automatic logic [21:0] ri(input logic [5:0] s);
    return {16'b0, s};
  endfunction

  // Expected outputs for cycles 1..N after the start cycle; d = MFC-low cycles before MFC rises.
  task automatic build(input logic [15:0] ins, input int d);
    logic [3:0]  opc;
    int          p1, p2, nw;
    logic [21:0] rw;
    opc = ins[15:12];
    p1  = int'(ins[11:6]);
    p2  = int'(ins[5:0]);
    exp_tr.delete();
    mfc_plan.delete();
    if (opc != OP_LD && opc != OP_ST) begin
      exp_tr.push_back('0);
      mfc_plan.push_back(2);
      return;
    end
    if (p1 >= NR || p2 >= NR) begin
      exp_tr.push_back(F_BUSY | F_DONE | F_ERR);
      mfc_plan.push_back(2);
      return;
    end
    rw = (opc == OP_LD) ? F_RW : '0;
    exp_tr.push_back(F_BUSY | F_PCINC | ro(sel(p2)));  mfc_plan.push_back(2);
    exp_tr.push_back(F_BUSY | F_MARIN | ro(sel(p2)));  mfc_plan.push_back(2);
    if (opc == OP_ST) begin
      exp_tr.push_back(F_BUSY | ro(sel(p1)));          mfc_plan.push_back(2);
      exp_tr.push_back(F_BUSY | F_MDRW | ro(sel(p1))); mfc_plan.push_back(2);
    end
    nw = (d < TMO) ? d + 1 : TMO;
    for (int j = 0; j < nw; j++) begin
      exp_tr.push_back(F_BUSY | F_MEMEN | rw);
      mfc_plan.push_back((j == d) ? 1 : 0);
    end
    if (d >= TMO) begin
      exp_tr.push_back(F_BUSY | F_DONE | F_ERR);       mfc_plan.push_back(2);
      return;
    end
    if (opc == OP_LD) begin
      exp_tr.push_back(F_BUSY | F_MEMEN | F_RW | F_MDRR);     mfc_plan.push_back(2);
      exp_tr.push_back(F_BUSY | F_MDROUT | F_RW);             mfc_plan.push_back(2);
      exp_tr.push_back(F_BUSY | F_MDROUT | F_RW | ri(sel(p1))); mfc_plan.push_back(2);
    end
    exp_tr.push_back(F_BUSY | F_DONE);                 mfc_plan.push_back(2);
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle; got[k] = outputs in cycle k.
  task automatic run_op(input logic [15:0] ins, input int d, input int rst_at);
    int n, p;
    build(ins, d);
    n = exp_tr.size();
    start = 1'b1;
    instruction = ins;
    MFC = 1'($urandom);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      got[k] = dut_vec;
      exp_vec = exp_tr[k-1];
      if (k == rst_at) begin
        rst = 1'b1;
        start = 1'b0;
        MFC = 1'($urandom);
        instruction = 16'($urandom);
        @(posedge clk); #1;
        got[k+1] = dut_vec;
        exp_vec = '0;
        rst = 1'b0;
        return;
      end
      p = mfc_plan[k-1];
      MFC = (p == 2) ? 1'($urandom) : (p == 1);
      start = exp_vec[21] ? 1'($urandom) : 1'b0;
      instruction = 16'($urandom);
    end
    @(posedge clk); #1;
    got[n+1] = dut_vec;
    exp_vec = '0;
    start = 1'b0;
    MFC = 1'($urandom);
    instruction = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_vec = '0;
      start = 1'b0;
      MFC = 1'($urandom);
      instruction = 16'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt;
    logic [5:0]  acc;
    rst = 1'b1;
    start = 1'b0;
    MFC = 1'b0;
    instruction = '0;
    exp_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Unknown opcode is ignored.
    run_op(16'h1042, 0, -1);
    chk("nonls_c1", 32'(got[1]), 32'd0);

    // Store r1 -> [r2], MFC in first wait cycle, then a back-to-back load.
    run_op(16'h4042, 0, -1);
    chk("st_c1_rxout", 32'(got[1][11:6]), 32'h08);
    chk("st_c1_pcinc", 32'(got[1][12]), 32'd1);
    chk("st_c2_marin", 32'(got[2][16]), 32'd1);
    chk("st_c4_rxout", 32'(got[4][11:6]), 32'h10);
    chk("st_c4_mdrw", 32'(got[4][15]), 32'd1);
    chk("st_c5_mem_rw", 32'(got[5][18:17]), 32'd2);
    chk("st_c6_done_err", 32'(got[6][20:19]), 32'd2);

    // Load r5 <- [r0], MFC rises in the last allowed wait cycle.
    run_op(16'h3140, 3, -1);
    chk("ld_c1_rxout", 32'(got[1][11:6]), 32'h20);
    chk("ld_c7_mdrr", 32'(got[7][14]), 32'd1);
    chk("ld_c9_rxin", 32'(got[9][5:0]), 32'h01);
    chk("ld_c10_done_err", 32'(got[10][20:19]), 32'd2);

    // Load with MFC stuck low times out.
    idle_cycles(1);
    run_op(16'h3083, 100, -1);
    cnt = 0;
    acc = '0;
    for (int k = 1; k <= 8; k++) begin
      cnt += int'(got[k][18]);
      acc |= got[k][5:0];
    end
    chk("to_memen_cycles", 32'(cnt), 32'd4);
    chk("to_rxin_quiet", 32'(acc), 32'd0);
    chk("to_c7_done_err", 32'(got[7][20:19]), 32'd3);
    chk("to_c7_memen", 32'(got[7][18]), 32'd0);

    // Address register 7 does not exist.
    run_op(16'h4047, 0, -1);
    chk("inv_c1_done_err", 32'(got[1][20:19]), 32'd3);
    chk("inv_no_strobes", 32'({got[1][18], got[1][16], got[1][12], got[2][18], got[2][16], got[2][12]}),
        32'd0);

    // Reset during the read wait aborts, then a store still takes six cycles.
    run_op(16'h3083, 100, 3);
    chk("rst_c3_memen", 32'(got[3][18]), 32'd1);
    chk("rst_c4_quiet", 32'(got[4]), 32'd0);
    run_op(16'h4042, 0, -1);
    chk("rst_st_c6_done", 32'(got[6][20:19]), 32'd2);

    // Randomised traffic, including timeouts, bad registers and foreign opcodes.
    for (int i = 0; i < 60; i++) begin
      int         r, d;
      logic [3:0] opc;
      logic [5:0] a, b;
      r = int'($urandom_range(0, 9));
      opc = (r < 4) ? OP_LD : (r < 8) ? OP_ST : (r == 8) ? 4'($urandom) : OP_LD;
      a = 6'($urandom_range(0, 5));
      b = 6'($urandom_range(0, 5));
      if (r == 9) b = 6'($urandom_range(6, 63));
      d = int'($urandom_range(0, 6));
      run_op({opc, a, b}, d, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
